// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC-source sequencer.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_REDIRECT,
    ST_EXEC,
    ST_EXC
  } pc_seq_state_e;

  localparam logic [2:0] PC_SRC_SEQ = 3'b010;
  localparam logic [2:0] PC_SRC_TGT = 3'b011;
  localparam logic [2:0] PC_SRC_EXC = 3'b000;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_OVF  = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       ir_write;
    logic       pc_write;
    logic [2:0] pc_source;
    logic       epc_write;
    logic       exec_start;
  } pc_seq_outs_t;

  // Moore output decode; tc is the FETCH terminal count, first marks EXEC entry.
  function automatic pc_seq_outs_t pc_seq_decode(input pc_seq_state_e st,
                                                 input logic tc,
                                                 input logic first);
    pc_seq_outs_t o;
    o = '0;
    o.pc_source = PC_SRC_SEQ;
    case (st)
      ST_FETCH: begin
        o.mem_read = 1'b1;
        o.ir_write = tc;
        o.pc_write = tc;
      end
      ST_REDIRECT: begin
        o.pc_write  = 1'b1;
        o.pc_source = PC_SRC_TGT;
      end
      ST_EXEC: o.exec_start = first;
      ST_EXC: begin
        o.pc_write  = 1'b1;
        o.pc_source = PC_SRC_EXC;
        o.epc_write = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pc_seq_lat_cnt.sv
// Instruction-fetch latency counter: counts 0..MEM_LAT-1 with terminal-count flags.
module pc_seq_lat_cnt #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o,
  output logic tc_nxt_o
);

  localparam logic [3:0] TC_VAL = 4'(MEM_LAT - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = 4'd0;
    else if (en_i) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == TC_VAL);
  // Lets the owner register outputs that depend on next cycle's count.
  assign tc_nxt_o = reset ? (TC_VAL == 4'd0) : (cnt_d == TC_VAL);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/redirect/exception sequencer driving the PC-source mux.
// PC_SEQ_EPC_EN enables illegal-op/overflow exceptions, epc_write and cause.
//
// state    | meaning
// FETCH    | instruction read, PC+4 load on the last latency cycle
// DECODE   | sample decode inputs, pick the next step
// REDIRECT | load branch/jump target over PC+4
// EXEC     | hand off to main control, wait for exec_done
// EXC      | load exception vector, capture EPC
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       is_jump,
  input  logic       is_branch,
  input  logic       branch_cond,
  input  logic       illegal_op,
  input  logic       overflow,
  input  logic       exec_done,
  output logic       mem_read,
  output logic       ir_write,
  output logic       pc_write,
  output logic [2:0] pc_source,
  output logic       epc_write,
  output logic [1:0] cause,
  output logic       exec_start
);

  pc_seq_state_e state_q, state_d;
  pc_seq_outs_t  outs_q;
  logic          cnt_clr, cnt_en, tc, tc_nxt;
`ifdef PC_SEQ_EPC_EN
  logic [1:0]    cause_q, cause_d;
`endif

  pc_seq_lat_cnt #(.MEM_LAT(MEM_LAT)) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .tc_o     (tc),
    .tc_nxt_o (tc_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
`ifdef PC_SEQ_EPC_EN
    cause_d = cause_q;
`endif
    case (state_q)
      ST_FETCH: begin
        if (tc) begin
          state_d = ST_DECODE;
        end else begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
        end
      end
      ST_DECODE: begin
`ifdef PC_SEQ_EPC_EN
        if (illegal_op) begin
          state_d = ST_EXC;
          cause_d = CAUSE_ILL;
        end else
`endif
        if (is_jump || (is_branch && branch_cond)) state_d = ST_REDIRECT;
        else                                       state_d = ST_EXEC;
      end
      ST_REDIRECT: state_d = ST_EXEC;
      ST_EXEC: begin
        if (exec_done) begin
`ifdef PC_SEQ_EPC_EN
          if (overflow) begin
            state_d = ST_EXC;
            cause_d = CAUSE_OVF;
          end else
`endif
          state_d = ST_FETCH;
        end
      end
      ST_EXC:  state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      outs_q  <= pc_seq_decode(ST_FETCH, tc_nxt, 1'b0);
`ifdef PC_SEQ_EPC_EN
      cause_q <= CAUSE_NONE;
`endif
    end else begin
      state_q <= state_d;
      outs_q  <= pc_seq_decode(state_d, tc_nxt,
                               (state_d == ST_EXEC) && (state_q != ST_EXEC));
`ifdef PC_SEQ_EPC_EN
      cause_q <= cause_d;
`endif
    end
  end

  // Strobes are suppressed while reset is high so pending writes are dropped.
  assign mem_read   = outs_q.mem_read   & ~reset;
  assign ir_write   = outs_q.ir_write   & ~reset;
  assign pc_write   = outs_q.pc_write   & ~reset;
  assign exec_start = outs_q.exec_start & ~reset;
  assign pc_source  = reset ? PC_SRC_SEQ : outs_q.pc_source;

`ifdef PC_SEQ_EPC_EN
  assign epc_write = outs_q.epc_write & ~reset;
  assign cause     = cause_q;
`else
  logic unused_exc;
  assign unused_exc = ^{illegal_op, overflow, outs_q.epc_write};
  assign epc_write  = 1'b0;
  assign cause      = CAUSE_NONE;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (MEM_LAT=2); follows PC_SEQ_EPC_EN if defined.
module tb_pc_sequencer;

  localparam int MEM_LAT = 2;

  // {mem_read, ir_write, pc_write, pc_source[2:0], epc_write, exec_start}
  localparam logic [7:0] V_F0   = 8'b1000_1000;
  localparam logic [7:0] V_F1   = 8'b1110_1000;
  localparam logic [7:0] V_IDLE = 8'b0000_1000;
  localparam logic [7:0] V_RDR  = 8'b0010_1100;
  localparam logic [7:0] V_EXS  = 8'b0000_1001;
  localparam logic [7:0] V_EXC  = 8'b0010_0010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       is_jump = 1'b0, is_branch = 1'b0, branch_cond = 1'b0;
  logic       illegal_op = 1'b0, overflow = 1'b0, exec_done = 1'b0;
  logic       mem_read, ir_write, pc_write, epc_write, exec_start;
  logic [2:0] pc_source;
  logic [1:0] cause;
  logic [7:0] outs;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign outs = {mem_read, ir_write, pc_write, pc_source, epc_write, exec_start};

  pc_sequencer #(.MEM_LAT(MEM_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .is_jump     (is_jump),
    .is_branch   (is_branch),
    .branch_cond (branch_cond),
    .illegal_op  (illegal_op),
    .overflow    (overflow),
    .exec_done   (exec_done),
    .mem_read    (mem_read),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_source   (pc_source),
    .epc_write   (epc_write),
    .cause       (cause),
    .exec_start  (exec_start)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample one cycle mid-period; inputs last one cycle, caller sets them after.
  task automatic cyc(input string tag, input logic [7:0] exp_o, input logic [1:0] exp_c);
    @(negedge clk);
    is_jump = 1'b0; is_branch = 1'b0; branch_cond = 1'b0;
    illegal_op = 1'b0; overflow = 1'b0; exec_done = 1'b0;
    chk(tag, outs, exp_o);
    chk({tag, "_cause"}, {6'b0, cause}, {6'b0, exp_c});
  endtask

  task automatic fetch(input string tag, input logic [1:0] exp_c);
    cyc({tag, "_f0"}, V_F0, exp_c);
    cyc({tag, "_f1"}, V_F1, exp_c);
  endtask

  logic [1:0] c_ovf, c_ill;

  initial begin
`ifdef PC_SEQ_EPC_EN
    c_ovf = 2'b10;
    c_ill = 2'b01;
`else
    c_ovf = 2'b00;
    c_ill = 2'b00;
`endif
    // reset held for three edges; strobes low while asserted
    cyc("rst_a", V_IDLE, 2'b00);
    cyc("rst_b", V_IDLE, 2'b00);
    @(posedge clk); #1 reset = 1'b0;

    // taken branch
    fetch("i1", 2'b00);
    cyc("i1_dec", V_IDLE, 2'b00); is_branch = 1'b1; branch_cond = 1'b1;
    cyc("i1_rdr", V_RDR, 2'b00);
    cyc("i1_exs", V_EXS, 2'b00); exec_done = 1'b1;

    // not-taken branch, overflow without exec_done ignored
    fetch("i2", 2'b00);
    cyc("i2_dec", V_IDLE, 2'b00); is_branch = 1'b1;
    cyc("i2_exs", V_EXS, 2'b00); overflow = 1'b1;
    cyc("i2_exw", V_IDLE, 2'b00);
    cyc("i2_exw2", V_IDLE, 2'b00); exec_done = 1'b1;

    // jump+branch treated as jump, then overflow on completion
    fetch("i3", 2'b00);
    cyc("i3_dec", V_IDLE, 2'b00); is_jump = 1'b1; is_branch = 1'b1;
    cyc("i3_rdr", V_RDR, 2'b00);
    cyc("i3_exs", V_EXS, 2'b00); exec_done = 1'b1; overflow = 1'b1;
`ifdef PC_SEQ_EPC_EN
    cyc("i3_exc", V_EXC, c_ovf);
`endif

    // illegal opcode
    fetch("i4", c_ovf);
    cyc("i4_dec", V_IDLE, c_ovf); illegal_op = 1'b1;
`ifdef PC_SEQ_EPC_EN
    cyc("i4_exc", V_EXC, c_ill);
`else
    cyc("i4_exs", V_EXS, c_ill); exec_done = 1'b1;
`endif

    // reset lands in REDIRECT
    fetch("i5", c_ill);
    cyc("i5_dec", V_IDLE, c_ill); is_jump = 1'b1;
    @(posedge clk); #1 reset = 1'b1;
    cyc("i5_rdr_rst", V_IDLE, c_ill);
    @(posedge clk); #1 reset = 1'b0;

    // plain sequential instruction after reset
    fetch("i6", 2'b00);
    cyc("i6_dec", V_IDLE, 2'b00);
    cyc("i6_exs", V_EXS, 2'b00); exec_done = 1'b1;
    fetch("i7", 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
